ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-002 Parameter BHT_IDX_W, default 6, BHT index width (2^BHT_IDX_W entries); used only with BHT_EN.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  synchronous active-low reset, sampled on the rising edge of clk_in.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 ic_req  output  1  icache fetch request, level-held until ic_ready.
REQ-007 ic_addr  output  32  halfword-aligned fetch address.
REQ-008 ic_ready  input  1  icache response valid this cycle.
REQ-009 ic_data  input  32  instruction bits at ic_addr (bits [15:0] meaningful for compressed).
REQ-010 is_ins  output  1  instruction valid to decode.
REQ-011 ins_addr  output  32  PC of presented instruction.
REQ-012 ins  output  32  raw instruction word.
REQ-013 pred_jmp  output  1  predicted taken.
REQ-014 pred_another  output  32  non-predicted path address.
REQ-015 f_stall  input  1  decode cannot accept this cycle.
REQ-016 rob_clear  input  1  mispredict flush.
REQ-017 rob_new_pc  input  32  redirect target, valid with rob_clear.
REQ-018 rob_br_upd, rob_br_pc[31:0], rob_br_taken  input  committed-branch outcome; ignored without BHT_EN.

Function
REQ-019 FSM states: FLUSH, FETCH, HOLD; transitions only when rdy_in=1.
REQ-020 FLUSH: ic_req=0, is_ins=0; next state FETCH after one cycle.
REQ-021 FETCH: ic_req=1, ic_addr=pc; on ic_ready latch ic_data, compute prediction, set is_ins=1, ins_addr=pc, go HOLD.
REQ-022 HOLD: outputs stable; on an edge with f_stall=0, instruction is consumed: is_ins<=0, pc<=predicted next PC, go FETCH.
REQ-023 Minimum issue interval: 2 cycles/instruction with a 1-cycle icache response (FETCH 1 cycle, HOLD 1 cycle).
REQ-024 Length: 4 if ins[1:0]==2'b11, else 2; fall-through = pc+len, 32-bit wrap-around.
REQ-025 Targets: B-type pc+immB; JAL pc+immJ; c.j/c.jal (quadrant 01, funct3 101/001) pc+immCJ; c.beqz/c.bnez (01, 110/111) pc+immCB; all sign-extended, modulo 2^32.
REQ-026 JAL, c.j, c.jal: pred_jmp=1, next=target, pred_another=pc+len.
REQ-027 Conditional branch: pred_jmp per REQ-035/036; next=pred_jmp?target:pc+len; pred_another=other one.
REQ-028 JALR, c.jr, c.jalr and all non-control instructions: pred_jmp=0, next=pc+len, pred_another=pc+len.
REQ-029 rob_clear=1 (any state, highest priority, while rdy_in=1): pc<=rob_new_pc, is_ins<=0, state<=FLUSH; any concurrent ic_ready data discarded.
REQ-030 rdy_in=0: state, pc, outputs and BHT hold; rob_clear, ic_ready and updates ignored.
REQ-031 ic_ready outside FETCH ignored.

Reset
REQ-032 rst_in=0 at a clock edge: pc<=RESET_PC, state<=FLUSH, is_ins=0, ic_req=0, pred_jmp=0, ins_addr=0, ins=0, pred_another=0, ic_addr=RESET_PC; reset overrides rdy_in and rob_clear.
REQ-033 Reset mid-FETCH abandons the request; first post-reset request issues two cycles after rst_in rises.
REQ-034 With BHT_EN, reset sets every counter to 2'b01.

Configuration
REQ-035 Macro BHT_EN defined: 2-bit saturating counter table indexed by pc[BHT_IDX_W:1]; predict taken iff counter[1]; rob_br_upd increments (sat 11) if rob_br_taken else decrements (sat 00) entry at rob_br_pc[BHT_IDX_W:1]; same-cycle read and update of one entry predicts with the pre-update value.
REQ-036 BHT_EN undefined: no table; static backward-taken: pred_jmp = sign bit of branch offset; update ports unconnected internally.

Verification
REQ-037 Reset release, 1-cycle icache returning 32'h00000013 -> ic_addr=0 two cycles after reset; is_ins=1, ins_addr=0, pred_jmp=0, pred_another=4; next request at 4.
REQ-038 Compressed c.addi at 0x10 -> next ic_addr=0x12, pred_another=0x12.
REQ-039 Branch at 0x100, offset -8, static mode -> pred_jmp=1, next ic_addr=0xF8, pred_another=0x104; offset +8 -> pred_jmp=0, next 0x104, pred_another=0x108.
REQ-040 f_stall=1 for 3 cycles in HOLD -> outputs unchanged, no ic_req; advance on first f_stall=0 edge.
REQ-041 rob_clear with rob_new_pc=0x200 concurrent with ic_ready -> data discarded, is_ins=0, one FLUSH cycle, then ic_addr=0x200.
REQ-042 BHT_EN: two taken updates at 0x100 from reset -> branch at 0x100 predicted taken; two not-taken updates -> not taken.

Source files
------------

// File: rtl/ins_fetch_if.sv
// Fetch-unit bus bundle: icache request/response, decode handoff, ROB redirect and branch updates.
// master = fetch unit, slave = surrounding pipeline/icache.
interface ins_fetch_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_data;

    logic        is_ins;
    logic [31:0] ins_addr;
    logic [31:0] ins;
    logic        pred_jmp;
    logic [31:0] pred_another;
    logic        f_stall;

    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic        rob_br_upd;
    logic [31:0] rob_br_pc;
    logic        rob_br_taken;

    modport master (
        output ic_req, ic_addr, is_ins, ins_addr, ins, pred_jmp, pred_another,
        input  ic_ready, ic_data, f_stall, rob_clear, rob_new_pc,
               rob_br_upd, rob_br_pc, rob_br_taken
    );

    modport slave (
        input  ic_req, ic_addr, is_ins, ins_addr, ins, pred_jmp, pred_another,
        output ic_ready, ic_data, f_stall, rob_clear, rob_new_pc,
               rob_br_upd, rob_br_pc, rob_br_taken
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch: FLUSH/FETCH/HOLD sequencer with next-PC prediction; one instruction per 2 cycles at best.
// Define BHT_EN for a 2-bit counter branch history table; otherwise static backward-taken prediction.
module ins_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BHT_IDX_W = 6
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    ins_fetch_if.master  bus
);
    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        is_ins_q, is_ins_d;
    logic [31:0] ins_addr_q, ins_addr_d;
    logic [31:0] ins_q, ins_d;
    logic        pred_jmp_q, pred_jmp_d;
    logic [31:0] pred_another_q, pred_another_d;

    // Decode of the returning icache word against the current PC
    logic [31:0] insn;
    logic        is_rv32, is_br, is_jal, is_cj, is_cb;
    logic [31:0] len, fall_pc, imm, target, pred_next, pred_alt;
    logic        cond_taken, pj;

    assign insn    = bus.ic_data;
    assign is_rv32 = (insn[1:0] == 2'b11);
    assign is_br   = is_rv32 && (insn[6:0] == 7'b1100011);
    assign is_jal  = is_rv32 && (insn[6:0] == 7'b1101111);
    assign is_cj   = (insn[1:0] == 2'b01) && ((insn[15:13] == 3'b101) || (insn[15:13] == 3'b001));
    assign is_cb   = (insn[1:0] == 2'b01) && ((insn[15:13] == 3'b110) || (insn[15:13] == 3'b111));
    assign len     = is_rv32 ? 32'd4 : 32'd2;
    assign fall_pc = pc_q + len;

    always_comb begin
        imm = 32'd0;
        if (is_br)
            imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        else if (is_jal)
            imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
        else if (is_cj)
            imm = {{21{insn[12]}}, insn[8], insn[10:9], insn[6], insn[7], insn[2],
                   insn[11], insn[5:3], 1'b0};
        else if (is_cb)
            imm = {{24{insn[12]}}, insn[6:5], insn[2], insn[11:10], insn[4:3], 1'b0};
    end

    assign target = pc_q + imm;

`ifdef BHT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bht_q [BHT_N];
    logic [1:0]           bht_d [BHT_N];
    logic [BHT_IDX_W-1:0] rd_idx, upd_idx;
    logic                 unused_br;

    assign rd_idx     = pc_q[BHT_IDX_W:1];
    assign upd_idx    = bus.rob_br_pc[BHT_IDX_W:1];
    // Prediction reads bht_q, so a same-cycle update to this entry is not yet visible
    assign cond_taken = bht_q[rd_idx][1];
    assign unused_br  = ^{bus.rob_br_pc[31:BHT_IDX_W+1], bus.rob_br_pc[0], bus.rob_new_pc[0]};

    always_comb begin
        bht_d = bht_q;
        if (rdy_in && bus.rob_br_upd) begin
            if (bus.rob_br_taken && (bht_q[upd_idx] != 2'b11))
                bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
            else if (!bus.rob_br_taken && (bht_q[upd_idx] != 2'b00))
                bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_N; i++)
                bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end
`else
    logic unused_br;

    assign cond_taken = imm[31];
    assign unused_br  = ^{bus.rob_br_upd, bus.rob_br_pc, bus.rob_br_taken, bus.rob_new_pc[0]};
`endif

    assign pj        = is_jal || is_cj || ((is_br || is_cb) && cond_taken);
    assign pred_next = pj ? target : fall_pc;
    assign pred_alt  = pj ? fall_pc : ((is_br || is_cb) ? target : fall_pc);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        next_pc_d      = next_pc_q;
        is_ins_d       = is_ins_q;
        ins_addr_d     = ins_addr_q;
        ins_d          = ins_q;
        pred_jmp_d     = pred_jmp_q;
        pred_another_d = pred_another_q;
        if (rdy_in) begin
            if (bus.rob_clear) begin
                pc_d     = {bus.rob_new_pc[31:1], 1'b0};
                is_ins_d = 1'b0;
                state_d  = ST_FLUSH;
            end else begin
                case (state_q)
                    ST_FLUSH: state_d = ST_FETCH;
                    ST_FETCH: begin
                        if (bus.ic_ready) begin
                            ins_d          = bus.ic_data;
                            ins_addr_d     = pc_q;
                            is_ins_d       = 1'b1;
                            pred_jmp_d     = pj;
                            pred_another_d = pred_alt;
                            next_pc_d      = pred_next;
                            state_d        = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!bus.f_stall) begin
                            is_ins_d = 1'b0;
                            pc_d     = next_pc_q;
                            state_d  = ST_FETCH;
                        end
                    end
                    default: state_d = ST_FLUSH;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q        <= ST_FLUSH;
            pc_q           <= RESET_PC;
            next_pc_q      <= RESET_PC;
            is_ins_q       <= 1'b0;
            ins_addr_q     <= 32'd0;
            ins_q          <= 32'd0;
            pred_jmp_q     <= 1'b0;
            pred_another_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            next_pc_q      <= next_pc_d;
            is_ins_q       <= is_ins_d;
            ins_addr_q     <= ins_addr_d;
            ins_q          <= ins_d;
            pred_jmp_q     <= pred_jmp_d;
            pred_another_q <= pred_another_d;
        end
    end

    assign bus.ic_req       = (state_q == ST_FETCH);
    assign bus.ic_addr      = pc_q;
    assign bus.is_ins       = is_ins_q;
    assign bus.ins_addr     = ins_addr_q;
    assign bus.ins          = ins_q;
    assign bus.pred_jmp     = pred_jmp_q;
    assign bus.pred_another = pred_another_q;
endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: vector table of decoded instructions plus hand-written corner sequences.
module tb_ins_fetch;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;

    always #5 clk = ~clk;

    ins_fetch_if bus ();

    ins_fetch dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        pj;
        logic [31:0] another;
        logic [31:0] next;
    } vec_t;

    vec_t vecs [11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Redirect to v.pc, return v.data in one cycle, check decode, consume, check next fetch address.
    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        bus.rob_clear  = 1'b1;
        bus.rob_new_pc = v.pc;
        cyc();
        chk1($sformatf("v%0d_flush_req", n), bus.ic_req, 1'b0);
        @(negedge clk);
        bus.rob_clear = 1'b0;
        cyc();
        chk($sformatf("v%0d_addr", n), bus.ic_addr, v.pc);
        @(negedge clk);
        bus.ic_ready = 1'b1;
        bus.ic_data  = v.data;
        cyc();
        chk1($sformatf("v%0d_is_ins", n), bus.is_ins, 1'b1);
        chk($sformatf("v%0d_ins_addr", n), bus.ins_addr, v.pc);
        chk1($sformatf("v%0d_pred_jmp", n), bus.pred_jmp, v.pj);
        chk($sformatf("v%0d_another", n), bus.pred_another, v.another);
        @(negedge clk);
        bus.ic_ready = 1'b0;
        bus.f_stall  = 1'b0;
        cyc();
        chk1($sformatf("v%0d_next_req", n), bus.ic_req, 1'b1);
        chk($sformatf("v%0d_next", n), bus.ic_addr, v.next);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.ic_ready     = 1'b0;
        bus.ic_data      = 32'd0;
        bus.f_stall      = 1'b0;
        bus.rob_clear    = 1'b0;
        bus.rob_new_pc   = 32'd0;
        bus.rob_br_upd   = 1'b0;
        bus.rob_br_pc    = 32'd0;
        bus.rob_br_taken = 1'b0;

        vecs[0]  = '{32'h0,   32'h00000013, 1'b0, 32'h4,   32'h4};
        vecs[1]  = '{32'h10,  32'h00000505, 1'b0, 32'h12,  32'h12};
`ifdef BHT_EN
        vecs[2]  = '{32'h100, 32'hFE000CE3, 1'b0, 32'hF8,  32'h104};
`else
        vecs[2]  = '{32'h100, 32'hFE000CE3, 1'b1, 32'h104, 32'hF8};
`endif
        vecs[3]  = '{32'h100, 32'h00000463, 1'b0, 32'h108, 32'h104};
        vecs[4]  = '{32'h200, 32'h0100006F, 1'b1, 32'h204, 32'h210};
        vecs[5]  = '{32'h0,   32'hFFDFF06F, 1'b1, 32'h4,   32'hFFFFFFFC};
        vecs[6]  = '{32'h300, 32'h0000BFFD, 1'b1, 32'h302, 32'h2FE};
        vecs[7]  = '{32'h400, 32'h0000C011, 1'b0, 32'h404, 32'h402};
`ifdef BHT_EN
        vecs[8]  = '{32'h400, 32'h0000FC75, 1'b0, 32'h3FC, 32'h402};
`else
        vecs[8]  = '{32'h400, 32'h0000FC75, 1'b1, 32'h402, 32'h3FC};
`endif
        vecs[9]  = '{32'h500, 32'h00008067, 1'b0, 32'h504, 32'h504};
        vecs[10] = '{32'h600, 32'h00008082, 1'b0, 32'h602, 32'h602};

        // Reset state
        repeat (3) cyc();
        chk1("rst_ic_req", bus.ic_req, 1'b0);
        chk1("rst_is_ins", bus.is_ins, 1'b0);
        chk("rst_ic_addr", bus.ic_addr, 32'h0);
        chk1("rst_pred_jmp", bus.pred_jmp, 1'b0);
        chk("rst_ins", bus.ins, 32'h0);
        chk("rst_ins_addr", bus.ins_addr, 32'h0);
        chk("rst_another", bus.pred_another, 32'h0);

        // Release: one FLUSH cycle, then request at RESET_PC
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk1("first_req", bus.ic_req, 1'b1);
        chk("first_addr", bus.ic_addr, 32'h0);
        @(negedge clk);
        bus.ic_ready = 1'b1;
        bus.ic_data  = 32'h00000013;
        cyc();
        chk1("nop_is_ins", bus.is_ins, 1'b1);
        chk("nop_ins", bus.ins, 32'h00000013);
        chk1("nop_pj", bus.pred_jmp, 1'b0);
        chk("nop_another", bus.pred_another, 32'h4);
        @(negedge clk);
        bus.ic_ready = 1'b0;
        cyc();
        chk("nop_next", bus.ic_addr, 32'h4);

        // Decode stall for 3 cycles; ic_ready while holding is ignored
        @(negedge clk);
        bus.ic_ready = 1'b1;
        bus.ic_data  = 32'h00100093;
        bus.f_stall  = 1'b1;
        cyc();
        @(negedge clk);
        bus.ic_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1($sformatf("stall%0d_is_ins", i), bus.is_ins, 1'b1);
            chk1($sformatf("stall%0d_req", i), bus.ic_req, 1'b0);
            chk($sformatf("stall%0d_ins", i), bus.ins, 32'h00100093);
            chk($sformatf("stall%0d_ins_addr", i), bus.ins_addr, 32'h4);
        end
        @(negedge clk);
        bus.f_stall  = 1'b0;
        bus.ic_ready = 1'b0;
        cyc();
        chk1("unstall_is_ins", bus.is_ins, 1'b0);
        chk1("unstall_req", bus.ic_req, 1'b1);
        chk("unstall_addr", bus.ic_addr, 32'h8);

        // Redirect concurrent with icache response
        @(negedge clk);
        bus.ic_ready   = 1'b1;
        bus.ic_data    = 32'h00000013;
        bus.rob_clear  = 1'b1;
        bus.rob_new_pc = 32'h200;
        cyc();
        chk1("clr_is_ins", bus.is_ins, 1'b0);
        chk1("clr_req", bus.ic_req, 1'b0);
        @(negedge clk);
        bus.ic_ready  = 1'b0;
        bus.rob_clear = 1'b0;
        cyc();
        chk1("clr_next_req", bus.ic_req, 1'b1);
        chk("clr_next_addr", bus.ic_addr, 32'h200);

        // rdy_in low freezes everything, including redirect and response
        @(negedge clk);
        rdy            = 1'b0;
        bus.ic_ready   = 1'b1;
        bus.ic_data    = 32'h00000013;
        bus.rob_clear  = 1'b1;
        bus.rob_new_pc = 32'h300;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk1($sformatf("frz%0d_req", i), bus.ic_req, 1'b1);
            chk1($sformatf("frz%0d_is_ins", i), bus.is_ins, 1'b0);
            chk($sformatf("frz%0d_addr", i), bus.ic_addr, 32'h200);
        end
        @(negedge clk);
        rdy           = 1'b1;
        bus.rob_clear = 1'b0;
        cyc();
        chk1("thaw_is_ins", bus.is_ins, 1'b1);
        chk("thaw_ins_addr", bus.ins_addr, 32'h200);
        @(negedge clk);
        bus.ic_ready = 1'b0;

        for (int n = 0; n < 11; n++)
            run_vec(vecs[n], n);

`ifdef BHT_EN
        @(negedge clk);
        bus.rob_br_upd   = 1'b1;
        bus.rob_br_pc    = 32'h100;
        bus.rob_br_taken = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.rob_br_upd = 1'b0;
        run_vec('{32'h100, 32'h00000463, 1'b1, 32'h104, 32'h108}, 20);
        @(negedge clk);
        bus.rob_br_upd   = 1'b1;
        bus.rob_br_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.rob_br_upd = 1'b0;
        run_vec('{32'h100, 32'h00000463, 1'b0, 32'h108, 32'h104}, 21);
`endif

        // Reset mid-FETCH abandons the pending request
        @(negedge clk);
        rst_n        = 1'b0;
        bus.ic_ready = 1'b1;
        bus.ic_data  = 32'h00000013;
        cyc();
        chk1("mid_rst_req", bus.ic_req, 1'b0);
        chk1("mid_rst_is_ins", bus.is_ins, 1'b0);
        chk("mid_rst_addr", bus.ic_addr, 32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.ic_ready = 1'b0;
        cyc();
        chk1("post_rst_is_ins", bus.is_ins, 1'b0);
        chk1("post_rst_req", bus.ic_req, 1'b1);
        chk("post_rst_addr", bus.ic_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
